ps2_mouse_init_ctrl: RTL and testbench
======================================

PS2_MOUSE_INIT_CTRL -- requirements
Module: ps2_mouse_init_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 1_000_000, cycles allowed per tx-completion or ACK wait (20 ms at 50 MHz).
REQ-002 Parameter BAT_TIMEOUT, default 50_000_000, cycles allowed for the BAT (0xAA) and ID (0x00) waits (1 s at 50 MHz).
REQ-003 Parameter MAX_RETRY, default 3, number of failed attempts after which the block enters FAIL.
REQ-004 qzt_clk  in  1  sole clock; all logic on the rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin the mouse init sequence.
REQ-007 tx_data  out  8  command byte to the PS/2 transmitter.
REQ-008 tx_send  out  1  one-cycle transmit request.
REQ-009 tx_ok  in  1  one-cycle pulse: transmitter finished and device acknowledged the bit frame.
REQ-010 tx_err  in  1  one-cycle pulse: transmitter aborted or line error.
REQ-011 rx_valid  in  1  one-cycle pulse: rx_data holds a received byte.
REQ-012 rx_data  in  8  received byte, valid only while rx_valid=1.
REQ-013 busy  out  1  high in every state except IDLE, DONE and FAIL.
REQ-014 done  out  1  high while in DONE.
REQ-015 fail  out  1  high while in FAIL.
REQ-016 state  out  4  current state code for LED debug.
REQ-017 retries  out  2  attempts consumed since last start.

Function
REQ-018 States and codes: IDLE=0, SEND_RST=1, WAIT_TX_RST=2, WAIT_ACK_RST=3, WAIT_BAT=4, WAIT_ID=5, SEND_EN=6, WAIT_TX_EN=7, WAIT_ACK_EN=8, DONE=9, FAIL=10.
REQ-019 IDLE, DONE, FAIL: start=1 -> SEND_RST next cycle; retries cleared to 0.
REQ-020 start while busy=1 shall be ignored.
REQ-021 SEND_RST: tx_data=0xFF and tx_send=1 for exactly one cycle, then WAIT_TX_RST; SEND_EN identical with 0xF4, then WAIT_TX_EN.
REQ-022 tx_data holds its value from the SEND state until the following SEND state or reset.
REQ-023 WAIT_TX_x: tx_ok -> WAIT_ACK_x; tx_err or timeout -> retry event.
REQ-024 WAIT_ACK_RST: rx 0xFA -> WAIT_BAT; WAIT_BAT: rx 0xAA -> WAIT_ID; WAIT_ID: rx 0x00 -> SEND_EN; WAIT_ACK_EN: rx 0xFA -> DONE.
REQ-025 Any other received byte in a receive state -> retry event; 0xFE (resend) in WAIT_ACK_x shall instead retry into the same command's SEND state.
REQ-026 rx_valid in non-receive states shall be ignored.
REQ-027 Timeout counter: cleared on every state entry, increments each cycle in WAIT states; expiry at count = ACK_TIMEOUT-1 (WAIT_TX_x, WAIT_ACK_x) or BAT_TIMEOUT-1 (WAIT_BAT, WAIT_ID).
REQ-028 Retry event: retries increments; if new value == MAX_RETRY -> FAIL, else -> SEND_RST (or the REQ-025 resend target).
REQ-029 Simultaneous tx_ok and tx_err: tx_err wins.
REQ-030 rx_valid in the same cycle as timeout expiry: the received byte is evaluated and the timeout is discarded.
REQ-031 retries saturates at MAX_RETRY; no wrap.
REQ-032 Counter width shall hold max(ACK_TIMEOUT, BAT_TIMEOUT) without overflow.

Reset
REQ-033 reset_n=0 forces, asynchronously: state IDLE, tx_send=0, tx_data=0x00, busy=0, done=0, fail=0, retries=0, timeout counter=0.
REQ-034 Reset mid-sequence abandons the transaction; after release the block remains in IDLE until start.

Verification
REQ-035 Happy path: start; tx_ok; rx FA, AA, 00; tx_ok; rx FA -> tx_send pulses with tx_data FF then F4, done=1, state=9, retries=0.
REQ-036 Wrong byte: rx 0xFC in WAIT_ACK_RST -> retries=1, state=1, tx_send pulse with 0xFF.
REQ-037 Timeout: no response after tx_ok with ACK_TIMEOUT=100 -> retry exactly 100 cycles after entering WAIT_ACK_RST; three timeouts -> fail=1, state=10, retries=3.
REQ-038 Resend: rx 0xFE in WAIT_ACK_EN -> state=6, tx_data=0xF4, retries incremented.
REQ-039 Collisions: tx_ok with tx_err same cycle -> retry; start while busy -> no effect.
REQ-040 Reset: reset_n low during WAIT_BAT -> all outputs at REQ-033 values the same cycle; start after release -> tx_send with 0xFF.

Source files
------------

// File: rtl/ps2_mouse_init_ctrl_if.sv
// ps2_mouse_init_ctrl_if
//   Bundles the control and PS/2 transceiver signals of the mouse init
//   controller. The clock and reset stay outside as plain ports.
//
//   Signals
//     start     : one-cycle request to run the init sequence
//     tx_data   : command byte presented to the PS/2 transmitter
//     tx_send   : one-cycle transmit request
//     tx_ok     : one-cycle pulse, frame sent and acknowledged at bit level
//     tx_err    : one-cycle pulse, transmitter abort or line error
//     rx_valid  : one-cycle pulse, rx_data holds a received byte
//     rx_data   : received byte (meaningful only while rx_valid=1)
//     busy      : sequence in progress
//     done      : sequence completed
//     fail      : sequence gave up after too many attempts
//     state     : current state code, for LED debug
//     retries   : attempts consumed since the last start
//
//   Handshake: every request/response here is a single-cycle pulse with no
//   back-pressure. A pulse is sampled on the one rising edge at which it is
//   high; the sender never holds it and the receiver never stalls it.
//
//   master : the controller side
//   slave  : the transceiver/host side
interface ps2_mouse_init_ctrl_if;
   logic       start;
   logic [7:0] tx_data;
   logic       tx_send;
   logic       tx_ok;
   logic       tx_err;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       busy;
   logic       done;
   logic       fail;
   logic [3:0] state;
   logic [1:0] retries;

   modport master (
      input  start, tx_ok, tx_err, rx_valid, rx_data,
      output tx_data, tx_send, busy, done, fail, state, retries
   );

   modport slave (
      output start, tx_ok, tx_err, rx_valid, rx_data,
      input  tx_data, tx_send, busy, done, fail, state, retries
   );
endinterface

// File: rtl/ps2_mouse_init_ctrl.sv
// ps2_mouse_init_ctrl
//   Brings up a PS/2 mouse: sends Reset (0xFF), expects ACK (0xFA), the
//   self-test pass code (0xAA) and the device ID (0x00), then sends Enable
//   Data Reporting (0xF4) and expects ACK (0xFA). Any wrong byte, transmit
//   error or timeout consumes one attempt and restarts from Reset; a Resend
//   (0xFE) in place of an ACK repeats just that command. After MAX_RETRY
//   attempts the block parks in FAIL.
//
//   Ports
//     qzt_clk : sole clock, rising edge
//     reset_n : asynchronous active-low reset
//     bus     : ps2_mouse_init_ctrl_if.master (see interface header)
//
//   Parameters
//     ACK_TIMEOUT : cycles allowed for each tx-completion or ACK wait
//     BAT_TIMEOUT : cycles allowed for the self-test and ID waits
//     MAX_RETRY   : failed attempts before FAIL (1..3, retries is 2 bits)
module ps2_mouse_init_ctrl #(
   parameter int ACK_TIMEOUT = 1_000_000,
   parameter int BAT_TIMEOUT = 50_000_000,
   parameter int MAX_RETRY   = 3
) (
   input  logic                  qzt_clk,
   input  logic                  reset_n,
   ps2_mouse_init_ctrl_if.master bus
);

   localparam int CNT_MAX = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0] BAT_LAST  = CW'(BAT_TIMEOUT - 1);
   localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);

   typedef enum logic [3:0] {
      IDLE         = 4'd0,
      SEND_RST     = 4'd1,
      WAIT_TX_RST  = 4'd2,
      WAIT_ACK_RST = 4'd3,
      WAIT_BAT     = 4'd4,
      WAIT_ID      = 4'd5,
      SEND_EN      = 4'd6,
      WAIT_TX_EN   = 4'd7,
      WAIT_ACK_EN  = 4'd8,
      DONE         = 4'd9,
      FAIL         = 4'd10
   } state_t;

   state_t        state_q, state_d, retry_tgt;
   logic [1:0]    retries_q, retries_d;
   logic [2:0]    retry_cnt;
   logic [7:0]    tx_data_q;
   logic [CW-1:0] cnt_q;
   logic          ack_wait, bat_wait, expired, do_retry;

   assign ack_wait  = state_q inside {WAIT_TX_RST, WAIT_ACK_RST, WAIT_TX_EN, WAIT_ACK_EN};
   assign bat_wait  = state_q inside {WAIT_BAT, WAIT_ID};
   assign expired   = (ack_wait && (cnt_q == ACK_LAST)) || (bat_wait && (cnt_q == BAT_LAST));
   assign retry_cnt = {1'b0, retries_q} + 3'd1;

   // A received byte is always decoded before the timeout is considered, so
   // a byte arriving on the expiry cycle still counts.
   always_comb begin
      state_d   = state_q;
      retries_d = retries_q;
      do_retry  = 1'b0;
      retry_tgt = SEND_RST;
      case (state_q)
         IDLE, DONE, FAIL: begin
            if (bus.start) begin
               state_d   = SEND_RST;
               retries_d = '0;
            end
         end
         SEND_RST: state_d = WAIT_TX_RST;
         SEND_EN:  state_d = WAIT_TX_EN;
         WAIT_TX_RST, WAIT_TX_EN: begin
            // tx_err outranks a coincident tx_ok.
            if (bus.tx_err)     do_retry = 1'b1;
            else if (bus.tx_ok) state_d  = (state_q == WAIT_TX_RST) ? WAIT_ACK_RST : WAIT_ACK_EN;
            else if (expired)   do_retry = 1'b1;
         end
         WAIT_ACK_RST: begin
            // Resend here targets SEND_RST, the same as the generic retry.
            if (bus.rx_valid) begin
               if (bus.rx_data == 8'hFA) state_d  = WAIT_BAT;
               else                      do_retry = 1'b1;
            end else if (expired) do_retry = 1'b1;
         end
         WAIT_BAT: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == 8'hAA) state_d  = WAIT_ID;
               else                      do_retry = 1'b1;
            end else if (expired) do_retry = 1'b1;
         end
         WAIT_ID: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == 8'h00) state_d  = SEND_EN;
               else                      do_retry = 1'b1;
            end else if (expired) do_retry = 1'b1;
         end
         WAIT_ACK_EN: begin
            if (bus.rx_valid) begin
               do_retry = (bus.rx_data != 8'hFA);
               if (bus.rx_data == 8'hFA) state_d   = DONE;
               if (bus.rx_data == 8'hFE) retry_tgt = SEND_EN;
            end else if (expired) do_retry = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (do_retry) begin
         retries_d = (retry_cnt > RETRY_MAX) ? retries_q : retry_cnt[1:0];
         state_d   = (retry_cnt >= RETRY_MAX) ? FAIL : retry_tgt;
      end
   end

   // tx_data is loaded on entry to a SEND state so it is already valid in
   // the tx_send cycle and then holds until the next SEND.
   always_ff @(posedge qzt_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         retries_q <= '0;
         tx_data_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         retries_q <= retries_d;
         if (state_d == SEND_RST)     tx_data_q <= 8'hFF;
         else if (state_d == SEND_EN) tx_data_q <= 8'hF4;
         if (state_d != state_q)          cnt_q <= '0;
         else if (ack_wait || bat_wait)   cnt_q <= cnt_q + CW'(1);
      end
   end

   assign bus.tx_data = tx_data_q;
   assign bus.tx_send = (state_q == SEND_RST) || (state_q == SEND_EN);
   assign bus.busy    = !(state_q inside {IDLE, DONE, FAIL});
   assign bus.done    = (state_q == DONE);
   assign bus.fail    = (state_q == FAIL);
   assign bus.state   = state_q;
   assign bus.retries = retries_q;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// tb_ps2_mouse_init_ctrl
//   Drives ps2_mouse_init_ctrl through directed and random init sequences.
//   A transaction-level model of the mouse protocol predicts every output
//   event (tx_send pulse, entry to DONE, entry to FAIL) with the cycle at
//   which it must appear; a monitor compares observed events in order.
module tb_ps2_mouse_init_ctrl;

   localparam int ACK_T = 100;
   localparam int BAT_T = 200;
   localparam int MAXR  = 3;
   localparam int W     = 49;

   localparam int A_OK = 0, A_BAD = 1, A_TMO = 2, A_FE = 3, A_BOTH = 4, A_EDGE = 5, A_RST = 6;
   localparam int A_BYTE = 256;

   logic qzt_clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   logic [W-1:0] exp_q[$];
   int           force_q[$];

   int         retries_m;
   logic [7:0] last_cmd;
   int         entry;
   int         next_kind;
   int         new_stage;

   ps2_mouse_init_ctrl_if bus();

   ps2_mouse_init_ctrl #(
      .ACK_TIMEOUT(ACK_T),
      .BAT_TIMEOUT(BAT_T),
      .MAX_RETRY  (MAXR)
   ) dut (
      .qzt_clk(qzt_clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 qzt_clk = ~qzt_clk;
   always @(posedge qzt_clk) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   function automatic logic [W-1:0] mk(input int c, input int st, input int r,
                                       input logic [7:0] d, input logic b,
                                       input logic dn, input logic fl);
      return {32'(c), 4'(st), 2'(r), d, b, dn, fl};
   endfunction

   function automatic string fmt(input logic [W-1:0] w);
      return $sformatf("cyc=%0d state=%0d retries=%0d tx_data=%h busy=%b done=%b fail=%b",
                       w[48:17], w[16:13], w[12:11], w[10:3], w[2], w[1], w[0]);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge qzt_clk);
      #1;
   endtask

   task automatic clear_in();
      bus.start    = 1'b0;
      bus.tx_ok    = 1'b0;
      bus.tx_err   = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
   endtask

   // One idle cycle with traffic the controller must ignore: start while
   // busy, and stray bytes while no byte is expected.
   task automatic noise(input bit tx_st);
      bus.start = ($urandom_range(0, 3) == 0);
      if (tx_st && ($urandom_range(0, 2) == 0)) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = 8'($urandom_range(0, 255));
      end
      tick();
      clear_in();
   endtask

   // ---------------- reference model ----------------
   // Stages: 0 tx of FF, 1 ACK of FF, 2 BAT, 3 ID, 4 tx of F4, 5 ACK of F4.
   function automatic logic [7:0] want_byte(input int stage);
      case (stage)
         1, 5:    return 8'hFA;
         2:       return 8'hAA;
         default: return 8'h00;
      endcase
   endfunction

   task automatic push_send(input int ev, input logic [7:0] cmd);
      exp_q.push_back(mk(ev, (cmd == 8'hFF) ? 1 : 6, retries_m, cmd, 1'b1, 1'b0, 1'b0));
      last_cmd  = cmd;
      next_kind = 1;
      new_stage = (cmd == 8'hFF) ? 0 : 4;
   endtask

   task automatic model_retry(input logic [7:0] target, input int ev);
      retries_m++;
      if (retries_m == MAXR) begin
         exp_q.push_back(mk(ev, 10, retries_m, last_cmd, 1'b0, 1'b0, 1'b1));
         next_kind = 2;
      end else begin
         push_send(ev, target);
      end
   endtask

   task automatic model_ok(input int stage, input int ev);
      next_kind = 0;
      new_stage = stage + 1;
      if (stage == 3) push_send(ev, 8'hF4);
      if (stage == 5) begin
         exp_q.push_back(mk(ev, 9, retries_m, 8'hF4, 1'b0, 1'b1, 1'b0));
         next_kind = 2;
      end
   endtask

   function automatic int pick(input int stage);
      int r;
      bit tx_st;
      tx_st = (stage == 0) || (stage == 4);
      if (force_q.size() > 0) return force_q.pop_front();
      r = $urandom_range(0, 99);
      if (r < 72) return A_OK;
      if (r < 82) return A_BAD;
      if (r < 85) return A_TMO;
      if (r < 93) return tx_st ? A_BOTH : (((stage == 1) || (stage == 5)) ? A_FE : A_BAD);
      return tx_st ? A_OK : A_EDGE;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, " state"},   32'(bus.state),   32'd0);
      chk({tag, " tx_send"}, 32'(bus.tx_send), 32'd0);
      chk({tag, " tx_data"}, 32'(bus.tx_data), 32'h00);
      chk({tag, " busy"},    32'(bus.busy),    32'd0);
      chk({tag, " done"},    32'(bus.done),    32'd0);
      chk({tag, " fail"},    32'(bus.fail),    32'd0);
      chk({tag, " retries"}, 32'(bus.retries), 32'd0);
   endtask

   task automatic mid_reset();
      #1 reset_n = 1'b0;
      #1 check_reset_outputs("mid_reset");
      tick();
      tick();
      #1 reset_n = 1'b1;
      repeat (3) tick();
      chk("post_reset idle state", 32'(bus.state), 32'd0);
      chk("post_reset busy",       32'(bus.busy),  32'd0);
      chk("post_reset pending",    32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- driver ----------------
   task automatic run_episode();
      int stage, act, lim, d, ev;
      bit tx_st, fin;
      logic [7:0] b;
      retries_m = 0;
      last_cmd  = 8'hFF;
      bus.start = 1'b1;
      exp_q.push_back(mk(cyc + 1, 1, 0, 8'hFF, 1'b1, 1'b0, 1'b0));
      tick();
      bus.start = 1'b0;
      tick();
      entry = cyc;
      stage = 0;
      fin   = 1'b0;
      while (!fin) begin
         act   = pick(stage);
         tx_st = (stage == 0) || (stage == 4);
         lim   = ((stage == 2) || (stage == 3)) ? BAT_T : ACK_T;
         if (act == A_RST) begin
            mid_reset();
            return;
         end
         if (act == A_TMO) begin
            ev = entry + lim;
            model_retry(8'hFF, ev);
            while (cyc < ev) noise(tx_st);
         end else begin
            d = (act == A_EDGE) ? lim - 1 : $urandom_range(0, 4);
            for (int k = 0; k < d; k++) noise(tx_st);
            ev = cyc + 1;
            if (tx_st) begin
               bus.tx_ok  = (act != A_BAD);
               bus.tx_err = (act == A_BAD) || (act == A_BOTH);
               if (bus.tx_err) model_retry(8'hFF, ev);
               else            model_ok(stage, ev);
            end else begin
               if (act >= A_BYTE)      b = 8'(act - A_BYTE);
               else if (act == A_FE)   b = 8'hFE;
               else if (act == A_BAD) begin
                  do b = 8'($urandom_range(0, 255)); while (b == want_byte(stage));
               end else                b = want_byte(stage);
               bus.rx_valid = 1'b1;
               bus.rx_data  = b;
               if (b == want_byte(stage))                        model_ok(stage, ev);
               else if ((b == 8'hFE) && (stage == 5))            model_retry(8'hF4, ev);
               else                                              model_retry(8'hFF, ev);
            end
            tick();
            clear_in();
         end
         if (next_kind == 0) begin
            entry = ev;
            stage = new_stage;
         end else if (next_kind == 1) begin
            tick();
            entry = cyc;
            stage = new_stage;
         end else begin
            fin = 1'b1;
         end
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic         done_prev = 1'b0;
   logic         fail_prev = 1'b0;
   logic [W-1:0] obs_w, exp_w;

   always @(negedge qzt_clk) begin
      if (bus.tx_send || (bus.done && !done_prev) || (bus.fail && !fail_prev)) begin
         obs_w = mk(cyc, int'(bus.state), int'(bus.retries), bus.tx_data,
                    bus.busy, bus.done, bus.fail);
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL event: got %s, expected no event", fmt(obs_w));
         end else begin
            exp_w = exp_q.pop_front();
            if (obs_w !== exp_w) begin
               miscompares++;
               $display("FAIL event: got %s, expected %s", fmt(obs_w), fmt(exp_w));
            end
         end
      end
      done_prev = bus.done;
      fail_prev = bus.fail;
   end

   // ---------------- watchdog ----------------
   initial begin
      repeat (95000) @(posedge qzt_clk);
      $display("FAIL watchdog: cycle budget expired, pending expectations %0d", exp_q.size());
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      clear_in();
      reset_n = 1'b0;
      tick();
      tick();
      check_reset_outputs("reset");
      #1 reset_n = 1'b1;
      tick();
      tick();
      chk("idle after reset", 32'(bus.state), 32'd0);

      // happy path
      repeat (6) force_q.push_back(A_OK);
      run_episode();
      // wrong byte 0xFC instead of ACK
      force_q.push_back(A_OK);
      force_q.push_back(A_BYTE + 32'hFC);
      repeat (6) force_q.push_back(A_OK);
      run_episode();
      // three ACK timeouts lead to FAIL
      repeat (3) begin
         force_q.push_back(A_OK);
         force_q.push_back(A_TMO);
      end
      run_episode();
      // resend on the enable ACK
      repeat (5) force_q.push_back(A_OK);
      force_q.push_back(A_FE);
      repeat (2) force_q.push_back(A_OK);
      run_episode();
      // tx_ok and tx_err together
      force_q.push_back(A_BOTH);
      repeat (6) force_q.push_back(A_OK);
      run_episode();
      // every byte on its timeout-expiry cycle
      force_q.push_back(A_OK);
      repeat (3) force_q.push_back(A_EDGE);
      force_q.push_back(A_OK);
      force_q.push_back(A_EDGE);
      run_episode();
      // reset in WAIT_BAT, then a fresh start
      force_q.push_back(A_OK);
      force_q.push_back(A_OK);
      force_q.push_back(A_RST);
      run_episode();
      repeat (6) force_q.push_back(A_OK);
      run_episode();

      for (int n = 0; n < 20; n++) run_episode();

      repeat (5) tick();
      chk("leftover expectations", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
